bm_logic_pipe: RTL and testbench
================================

Name: bm_logic_pipe

Overview:
- Parametrised successor to the registered-AND microbenchmark.
- Applies one of eight selectable bitwise operations to two WIDTH-bit operands and two 1-bit operands.
- Result travels through a STAGES-deep valid/ready pipeline with per-stage backpressure and bubble collapsing.
- Used as an ODIN microbenchmark for synthesising handshaked datapaths of configurable width and depth.

Parameters:
- WIDTH, 32: bit width of a_in, b_in, out0.
- STAGES, 2: pipeline depth in register stages. Legal range >= 1.
- CNT_W, 16: width of the delivered-result counter.

Ports:
- clock  in  1  sole clock; all state updates on posedge.
- reset_n  in  1  synchronous, active-low reset; sampled on posedge clock.
- in_valid  in  1  input beat present.
- in_ready  out  1  stage 0 can accept this cycle.
- op  in  3  operation select, sampled with the beat.
- a_in  in  WIDTH  operand A.
- b_in  in  WIDTH  operand B.
- c_in  in  1  scalar operand C.
- d_in  in  1  scalar operand D.
- out_valid  out  1  last stage holds a result.
- out_ready  in  1  downstream accepts.
- out0  out  WIDTH  vector result (last stage).
- out1  out  1  scalar result (last stage).
- res_count  out  CNT_W  number of results delivered since reset.

Behaviour:
- op encoding; the same function is applied to (a_in,b_in) -> out0 and to (c_in,d_in) -> out1:
  - 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 A&~B (ANDN), 7 PASS A.
- Function is evaluated combinationally at input and registered into stage 0. Stages 1..STAGES-1 only carry data. Last stage drives out0, out1, out_valid.
- Per-stage state: v[i], d0[i] (WIDTH), d1[i] (1).
- Stage load enable:
  - ld[i] = !v[i] || ld[i+1].
  - For the last stage: ld[STAGES-1] = !v[STAGES-1] || out_ready.
  - in_ready = ld[0]. This is a combinational ready chain; no registered skid.
- On posedge with ld[i]:
  - Stage 0: v[0] <= in_valid.
  - Stage i>0: v[i] <= v[i-1].
  - Data loads only when the source valid is 1. Data is held otherwise.
- Accept: in_valid && in_ready. Deliver: out_valid && out_ready.
- Latency: a beat accepted at edge k appears with out_valid=1 after edge k+STAGES-1, i.e. visible STAGES cycles after presentation, when there is no stall.
- Throughput: 1 beat/cycle while out_ready=1.
- Bubble collapse: an empty stage loads even while downstream is stalled. With out_ready=0 the pipe fills to exactly STAGES beats, then in_ready=0.
- Stalled output holds out0/out1 stable. Data must not change while out_valid && !out_ready.
- in_valid=0 while in_ready=1 inserts a bubble. No data loads are required.
- op values are all legal; no undefined encodings.
- res_count increments by 1 on each deliver and wraps modulo 2^CNT_W.
- Simultaneous accept and deliver are both honoured in the same cycle; occupancy is unchanged.
- Reset (reset_n=0 at posedge), including mid-operation:
  - All v[i]=0, all d0/d1=0, res_count=0.
  - Hence out_valid=0, out0=0, out1=0.
  - in_ready=1 from the first cycle after reset, and combinationally during reset since v=0.
  - In-flight beats are discarded. A beat presented in a reset cycle is not accepted.
- STAGES=1 degenerates to a single register with ready = !v || out_ready.

Optional Feature:
- Macro: BM_LOGIC_PIPE_PARITY_EN.
- Defined:
  - Adds output out_par (1) = XOR-reduce of the stage-0 out0 value, carried through the pipeline alongside d0.
  - Reset value 0; held under stall like out0.
- Undefined: port and its registers are absent; all other behaviour is identical.

Test Plan:
- Reset then STAGES=2, out_ready=1, one beat op=0, a=0xF0F0_F0F0, b=0xFF00_FF00, c=1, d=1 -> out_valid high 2 cycles later, out0=0xF000_F000, out1=1, res_count=1.
- Sweep op 0..7 with a=0xAAAA_5555, b=0x0F0F_0F0F, c=1, d=0 -> out0 = 0x0A0A_0505, 0xAFAF_5F5F, 0xA5A5_5A5A, 0xF5F5_FAFA, 0x5050_A0A0, 0x5A5A_A5A5, 0xA0A0_5050, 0xAAAA_5555. out1 = 0,1,1,1,0,0,1,1.
- Hold out_ready=0, stream 5 beats -> exactly STAGES=2 accepted, then in_ready=0. out0 is stable while stalled. Raising out_ready drains the beats in order, then the next beats follow at 1/cycle.
- Back-to-back stream of 10 beats with out_ready=1 -> 10 results in order, no gaps after initial latency, res_count=10. With CNT_W=3, res_count=2 (wrap).
- Pipe holding 2 beats, assert reset_n=0 for one cycle -> out_valid=0, out0=0, res_count=0 next cycle. The flushed beats never appear.
- With BM_LOGIC_PIPE_PARITY_EN: op=7, a=0x0000_0007 -> out_par=1 aligned with out0. Same run without the macro compiles with the port absent.

Source files
------------

// File: rtl/bm_logic_pipe.sv
// bm_logic_pipe: eight-function bitwise logic unit feeding a STAGES-deep
// valid/ready pipeline with per-stage backpressure and bubble collapsing.
// The function result is computed combinationally from the input operands
// and captured in stage 0; later stages only carry data to the output.
// Optional macro BM_LOGIC_PIPE_PARITY_EN adds out_par, the XOR-reduction of
// the vector result, carried alongside the data through every stage.
module bm_logic_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
  input  logic             d_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out0,
  output logic             out1,
`ifdef BM_LOGIC_PIPE_PARITY_EN
  output logic             out_par,
`endif
  output logic [CNT_W-1:0] res_count
);

  // Operation encodings; every 3-bit value is a legal operation.
  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_NAND = 3'd3;
  localparam logic [2:0] OP_NOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;
  localparam logic [2:0] OP_ANDN = 3'd6;
  localparam logic [2:0] OP_PASS = 3'd7;

  // Function outputs feeding stage 0.
  logic [WIDTH-1:0] w_res0;
  logic             w_res1;

  // Per-stage load enables and the output handshake.
  logic [STAGES-1:0] w_ld;
  logic              w_deliver;

  // Per-stage state: valid flag, vector data, scalar data.
  logic [STAGES-1:0] r_v;
  logic [WIDTH-1:0]  r_d0 [STAGES];
  logic [STAGES-1:0] r_d1;
  logic [CNT_W-1:0]  r_cnt;

`ifdef BM_LOGIC_PIPE_PARITY_EN
  logic              w_par;
  logic [STAGES-1:0] r_par;
`endif

  // Apply the selected bitwise function to both the vector and scalar pairs.
  always_comb begin
    w_res0 = '0;
    w_res1 = 1'b0;
    case (op)
      OP_AND:  begin w_res0 = a_in & b_in;    w_res1 = c_in & d_in;    end
      OP_OR:   begin w_res0 = a_in | b_in;    w_res1 = c_in | d_in;    end
      OP_XOR:  begin w_res0 = a_in ^ b_in;    w_res1 = c_in ^ d_in;    end
      OP_NAND: begin w_res0 = ~(a_in & b_in); w_res1 = ~(c_in & d_in); end
      OP_NOR:  begin w_res0 = ~(a_in | b_in); w_res1 = ~(c_in | d_in); end
      OP_XNOR: begin w_res0 = ~(a_in ^ b_in); w_res1 = ~(c_in ^ d_in); end
      OP_ANDN: begin w_res0 = a_in & ~b_in;   w_res1 = c_in & ~d_in;   end
      OP_PASS: begin w_res0 = a_in;           w_res1 = c_in;           end
      default: begin w_res0 = '0;             w_res1 = 1'b0;           end
    endcase
  end

  // The recursive ready chain ld[i] = !v[i] || ld[i+1] (ending in out_ready)
  // unrolls to: stage i may load if the output is being taken or any stage
  // from i to the end is empty. Writing it flat avoids a self-referencing
  // combinational vector while keeping the same per-stage meaning.
  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_ld
      assign w_ld[gi] = out_ready | ~(&r_v[STAGES-1:gi]);
    end
  endgenerate

  assign in_ready  = w_ld[0];
  assign w_deliver = r_v[STAGES-1] & out_ready;

  // Advance valid flags and data; data only moves when its source is valid,
  // so a stalled or bubbled stage keeps its previous contents.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_v  <= '0;
      r_d1 <= '0;
      for (int i = 0; i < STAGES; i++) begin
        r_d0[i] <= '0;
      end
    end else begin
      if (w_ld[0]) begin
        r_v[0] <= in_valid;
        if (in_valid) begin
          r_d0[0] <= w_res0;
          r_d1[0] <= w_res1;
        end
      end
      for (int i = 1; i < STAGES; i++) begin
        if (w_ld[i]) begin
          r_v[i] <= r_v[i-1];
          if (r_v[i-1]) begin
            r_d0[i] <= r_d0[i-1];
            r_d1[i] <= r_d1[i-1];
          end
        end
      end
    end
  end

  // Count delivered results; wraps naturally at 2^CNT_W.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (w_deliver) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

`ifdef BM_LOGIC_PIPE_PARITY_EN
  assign w_par = ^w_res0;

  // Carry the parity bit in lockstep with the vector data.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_par <= '0;
    end else begin
      if (w_ld[0] && in_valid) begin
        r_par[0] <= w_par;
      end
      for (int i = 1; i < STAGES; i++) begin
        if (w_ld[i] && r_v[i-1]) begin
          r_par[i] <= r_par[i-1];
        end
      end
    end
  end

  assign out_par = r_par[STAGES-1];
`endif

  assign out_valid = r_v[STAGES-1];
  assign out0      = r_d0[STAGES-1];
  assign out1      = r_d1[STAGES-1];
  assign res_count = r_cnt;

endmodule

// File: tb/tb_bm_logic_pipe.sv
// Testbench for bm_logic_pipe: directed beats push expected results into a
// scoreboard queue; a negedge monitor pops and compares on every delivery.
// A second instance with CNT_W=3 shares the stimulus to observe counter wrap.
module tb_bm_logic_pipe;

  logic        clock;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        c_in;
  logic        d_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out0;
  logic        out1;
  logic [15:0] res_count;

  logic        in_ready3;
  logic        out_valid3;
  logic [31:0] out0_3;
  logic        out1_3;
  logic [2:0]  res_count3;

`ifdef BM_LOGIC_PIPE_PARITY_EN
  logic        out_par;
  logic        out_par3;
`endif

  typedef struct {
    logic [31:0] d0;
    logic        d1;
  } exp_t;

  exp_t sb_q[$];
  int   errors    = 0;
  int   checks    = 0;
  int   delivered = 0;

  bm_logic_pipe #(.WIDTH(32), .STAGES(2), .CNT_W(16)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a_in(a_in), .b_in(b_in), .c_in(c_in), .d_in(d_in),
    .out_valid(out_valid), .out_ready(out_ready), .out0(out0), .out1(out1),
`ifdef BM_LOGIC_PIPE_PARITY_EN
    .out_par(out_par),
`endif
    .res_count(res_count)
  );

  bm_logic_pipe #(.WIDTH(32), .STAGES(2), .CNT_W(3)) dut3 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready3),
    .op(op), .a_in(a_in), .b_in(b_in), .c_in(c_in), .d_in(d_in),
    .out_valid(out_valid3), .out_ready(out_ready), .out0(out0_3), .out1(out1_3),
`ifdef BM_LOGIC_PIPE_PARITY_EN
    .out_par(out_par3),
`endif
    .res_count(res_count3)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Monitor: compare each delivered result against the scoreboard head and
  // verify that a stalled output does not change.
  logic [31:0] held0;
  logic        held1;
  bit          stall_prev = 0;
  always @(negedge clock) begin
    exp_t e;
    if (!reset_n) begin
      stall_prev = 0;
    end else if (out_valid && out_ready) begin
      stall_prev = 0;
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got out0=%h out1=%b, expected no output", out0, out1);
      end else begin
        e = sb_q.pop_front();
        if (out0 !== e.d0 || out1 !== e.d1) begin
          errors++;
          $display("FAIL result #%0d: got out0=%h out1=%b, expected out0=%h out1=%b",
                   delivered, out0, out1, e.d0, e.d1);
        end
        checks++;
        if (res_count !== 16'(delivered)) begin
          errors++;
          $display("FAIL res_count_at_deliver: got %0d, expected %0d", res_count, delivered);
        end
        checks++;
        if (res_count3 !== 3'(delivered)) begin
          errors++;
          $display("FAIL res_count3_at_deliver: got %0d, expected %0d", res_count3, 3'(delivered));
        end
`ifdef BM_LOGIC_PIPE_PARITY_EN
        checks++;
        if (out_par !== (^e.d0)) begin
          errors++;
          $display("FAIL out_par: got %b, expected %b", out_par, ^e.d0);
        end
`endif
        $display("deliver #%0d out0=%h out1=%b res_count=%0d", delivered, out0, out1, res_count);
        delivered++;
      end
    end else if (out_valid) begin
      if (stall_prev) begin
        checks++;
        if (out0 !== held0 || out1 !== held1) begin
          errors++;
          $display("FAIL stall_hold: got out0=%h out1=%b, expected out0=%h out1=%b",
                   out0, out1, held0, held1);
        end
      end
      held0 = out0;
      held1 = out1;
      stall_prev = 1;
    end else begin
      stall_prev = 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Present one beat for one cycle; it is accepted if in_ready is high.
  task automatic try_beat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic c, input logic d,
                          input logic [31:0] e0, input logic e1, output bit acc);
    exp_t e;
    op = o; a_in = a; b_in = b; c_in = c; d_in = d;
    in_valid = 1'b1;
    @(negedge clock);
    acc = in_ready;
    if (acc) begin
      e.d0 = e0;
      e.d1 = e1;
      sb_q.push_back(e);
    end
    $display("beat op=%0d a=%h b=%h c=%b d=%b accepted=%b", o, a, b, c, d, acc);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (sb_q.size() != 0 && n < 50) begin
      @(posedge clock);
      n++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d pending, expected 0", name, sb_q.size());
      sb_q.delete();
    end
    #1;
  endtask

  logic [31:0] sweep_exp0 [8];
  logic        sweep_exp1 [8];
  bit          acc;
  int          nacc;

  initial begin
    sweep_exp0[0] = 32'h0A0A_0505; sweep_exp1[0] = 1'b0;
    sweep_exp0[1] = 32'hAFAF_5F5F; sweep_exp1[1] = 1'b1;
    sweep_exp0[2] = 32'hA5A5_5A5A; sweep_exp1[2] = 1'b1;
    sweep_exp0[3] = 32'hF5F5_FAFA; sweep_exp1[3] = 1'b1;
    sweep_exp0[4] = 32'h5050_A0A0; sweep_exp1[4] = 1'b0;
    sweep_exp0[5] = 32'h5A5A_A5A5; sweep_exp1[5] = 1'b0;
    sweep_exp0[6] = 32'hA0A0_5050; sweep_exp1[6] = 1'b1;
    sweep_exp0[7] = 32'hAAAA_5555; sweep_exp1[7] = 1'b1;

    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = 3'd0; a_in = '0; b_in = '0; c_in = 1'b0; d_in = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;

    // Reset state.
    @(negedge clock);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out0", out0, 32'd0);
    chk("reset_out1", 32'(out1), 32'd0);
    chk("reset_res_count", 32'(res_count), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);

    // Single AND beat and its latency.
    step();
    try_beat(3'd0, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1, 1'b1, 32'hF000_F000, 1'b1, acc);
    chk("t1_accept", 32'(acc), 32'd1);
    @(negedge clock);
    chk("t1_valid_early", 32'(out_valid), 32'd0);
    @(negedge clock);
    chk("t1_valid_on_time", 32'(out_valid), 32'd1);
    @(negedge clock);
    chk("t1_res_count", 32'(res_count), 32'd1);
    step();

    // Sweep all eight operations back to back.
    for (int i = 0; i < 8; i++) begin
      try_beat(3'(i), 32'hAAAA_5555, 32'h0F0F_0F0F, 1'b1, 1'b0, sweep_exp0[i], sweep_exp1[i], acc);
      chk("sweep_accept", 32'(acc), 32'd1);
    end
    wait_drain("sweep");

    // Stall: with out_ready low exactly two beats fit.
    out_ready = 1'b0;
    nacc = 0;
    for (int i = 0; i < 5; i++) begin
      try_beat(3'd7, 32'h1111_0000 + 32'(i), 32'h0, i[0], 1'b0,
               32'h1111_0000 + 32'(i), i[0], acc);
      if (acc) nacc++;
    end
    chk("stall_accepted", 32'(nacc), 32'd2);
    @(negedge clock);
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    repeat (3) step();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      try_beat(3'd2, 32'h0000_FFFF, 32'h00FF_00FF << i, 1'b1, 1'b1,
               32'h0000_FFFF ^ (32'h00FF_00FF << i), 1'b0, acc);
      chk("post_stall_accept", 32'(acc), 32'd1);
    end
    wait_drain("stall");

    // Reset with two beats in flight: they must never appear.
    out_ready = 1'b0;
    try_beat(3'd1, 32'hDEAD_0000, 32'h0000_BEEF, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, acc);
    try_beat(3'd1, 32'hCAFE_0000, 32'h0000_F00D, 1'b0, 1'b0, 32'hCAFE_F00D, 1'b0, acc);
    reset_n = 1'b0;
    sb_q.delete();
    delivered = 0;
    step();
    reset_n = 1'b1;
    @(negedge clock);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_out0", out0, 32'd0);
    chk("flush_out1", 32'(out1), 32'd0);
    chk("flush_res_count", 32'(res_count), 32'd0);
    step();
    out_ready = 1'b1;
    repeat (4) step();
    @(negedge clock);
    chk("flush_no_output", 32'(out_valid), 32'd0);
    step();

    // Ten back-to-back PASS beats; counters end at 10 and 10 mod 8.
    for (int i = 0; i < 10; i++) begin
      try_beat(3'd7, 32'h1000_0000 + 32'(i), 32'hFFFF_FFFF, i[0], 1'b1,
               32'h1000_0000 + 32'(i), i[0], acc);
      chk("b2b_accept", 32'(acc), 32'd1);
    end
    wait_drain("b2b");
    chk("b2b_res_count", 32'(res_count), 32'd10);
    chk("b2b_res_count3", 32'(res_count3), 32'd2);

    // PASS of 7: parity of the result is 1 when the feature is present.
    try_beat(3'd7, 32'h0000_0007, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0000_0007, 1'b0, acc);
    chk("par_accept", 32'(acc), 32'd1);
    wait_drain("par");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
